pattern_player_ctrl: RTL and testbench

PATTERN_PLAYER_CTRL -- requirements
Module: pattern_player_ctrl

---
 rtl/pattern_player_ctrl_pkg.sv | 19 +
 rtl/pattern_player_ctrl_if.sv | 11 +
 rtl/pattern_player_ctrl_index_counter.sv | 58 +++++
 rtl/pattern_player_ctrl.sv | 125 ++++++++++++
 tb/tb_pattern_player_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pattern_player_ctrl_pkg.sv
// rtl/pattern_player_ctrl_pkg.sv - shared state encoding and playback mode constants
package pattern_player_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ONCE     = 2'b00;
    localparam logic [1:0] MODE_LOOP     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    // Mode 11 has no meaning of its own and plays like once.
    function automatic logic is_once(input logic [1:0] mode);
        return (mode != MODE_LOOP) && (mode != MODE_PINGPONG);
    endfunction

endpackage

// File: rtl/pattern_player_ctrl_if.sv
// rtl/pattern_player_ctrl_if.sv - pattern ROM fetch bus between controller and external ROM
interface pattern_player_ctrl_if #(
    parameter int ADDR_W = 6
) ();
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/pattern_player_ctrl_index_counter.sv
// rtl/pattern_player_ctrl_index_counter.sv - entry index within a bank with wrap, bounce and last-detect
module pattern_index_counter
    import pattern_player_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [IDX_W-1:0] i_last,
    input  logic [1:0]       i_mode,
    output logic [IDX_W-1:0] o_index_next,
    output logic             o_at_last
);

    logic [IDX_W-1:0] index_q, index_d;
    logic             up_q, up_d;

    assign o_at_last    = (index_q == i_last);
    assign o_index_next = index_d;

    // index_d is the value a step would produce; it is only committed on i_step.
    always_comb begin
        index_d = index_q;
        up_d    = up_q;
        if (i_mode == MODE_PINGPONG) begin
            if (i_last == '0) begin
                index_d = '0;
            end else if (up_q) begin
                if (o_at_last) begin
                    index_d = index_q - IDX_W'(1);
                    up_d    = 1'b0;
                end else begin
                    index_d = index_q + IDX_W'(1);
                end
            end else if (index_q == '0) begin
                index_d = IDX_W'(1);
                up_d    = 1'b1;
            end else begin
                index_d = index_q - IDX_W'(1);
            end
        end else begin
            index_d = o_at_last ? '0 : index_q + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            index_q <= '0;
            up_q    <= 1'b1;
        end else if (i_step) begin
            index_q <= index_d;
            up_q    <= up_d;
        end
    end

endmodule

// File: rtl/pattern_player_ctrl.sv
// rtl/pattern_player_ctrl.sv - plays a bank of LED patterns from an external ROM on divider ticks
module pattern_player_ctrl
    import pattern_player_ctrl_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 16
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_start,
    input  logic                                i_stop,
    input  logic                                i_pause,
    input  logic [$clog2(NUM_BANKS)-1:0]        i_bank,
    input  logic [$clog2(BANK_DEPTH)-1:0]       i_last,
    input  logic [1:0]                          i_mode,
    input  logic                                i_tick,
    pattern_player_ctrl_if.master               rom,
    output logic [3:0]                          o_leds,
    output logic                                o_busy,
    output logic                                o_done
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int IDX_W  = $clog2(BANK_DEPTH);
    localparam int ADDR_W = $clog2(NUM_BANKS * BANK_DEPTH);

    state_e             state_q, state_d;
    logic [BANK_W-1:0]  bank_q;
    logic [IDX_W-1:0]   last_q;
    logic [1:0]         mode_q;
    logic               rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               done_q, done_d;
    logic               pend_q;
    logic [3:0]         leds_q;
    logic               latch, cnt_clear, cnt_step;
    logic [IDX_W-1:0]   index_next;
    logic               at_last;

    pattern_index_counter #(.IDX_W(IDX_W)) u_index (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (cnt_clear),
        .i_step       (cnt_step),
        .i_last       (last_q),
        .i_mode       (mode_q),
        .o_index_next (index_next),
        .o_at_last    (at_last)
    );

    // Banks are power-of-two sized, so bank*BANK_DEPTH+index is a concatenation.
    always_comb begin
        state_d    = state_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        done_d     = 1'b0;
        latch      = 1'b0;
        cnt_clear  = 1'b0;
        cnt_step   = 1'b0;
        if (i_stop) begin
            state_d = ST_IDLE;
        end else if (i_start) begin
            state_d    = ST_RUN;
            latch      = 1'b1;
            cnt_clear  = 1'b1;
            rom_en_d   = 1'b1;
            rom_addr_d = {i_bank, {IDX_W{1'b0}}};
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_pause) begin
                        state_d = ST_PAUSE;
                    end else if (i_tick) begin
                        if (is_once(mode_q) && at_last) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_step   = 1'b1;
                            rom_en_d   = 1'b1;
                            rom_addr_d = {bank_q, index_next};
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_pause) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A fetch issued before i_stop still lands; only reset discards it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            bank_q     <= '0;
            last_q     <= '0;
            mode_q     <= MODE_ONCE;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            leds_q     <= '0;
        end else begin
            state_q    <= state_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            done_q     <= done_d;
            pend_q     <= rom_en_q;
            if (latch) begin
                bank_q <= i_bank;
                last_q <= i_last;
                mode_q <= i_mode;
            end
            if (pend_q) leds_q <= rom.rom_data;
        end
    end

    assign rom.rom_en   = rom_en_q;
    assign rom.rom_addr = rom_addr_q;
    assign o_leds       = leds_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;

endmodule

// File: tb/tb_pattern_player_ctrl.sv
// tb/tb_pattern_player_ctrl.sv - randomized and directed bench with a behavioural playback model
module tb_pattern_player_ctrl;

    localparam int NB = 4;
    localparam int BD = 16;
    localparam int AW = 6;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, tick;
    logic [1:0] bank;
    logic [3:0] last;
    logic [1:0] mode;
    logic [3:0] leds;
    logic       busy, done;

    always #5 clk = ~clk;

    pattern_player_ctrl_if #(.ADDR_W(AW)) rom_bus ();

    pattern_player_ctrl #(.NUM_BANKS(NB), .BANK_DEPTH(BD)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .i_stop  (stop),
        .i_pause (pause),
        .i_bank  (bank),
        .i_last  (last),
        .i_mode  (mode),
        .i_tick  (tick),
        .rom     (rom_bus),
        .o_leds  (leds),
        .o_busy  (busy),
        .o_done  (done)
    );

    logic [3:0] rom_mem [0:NB*BD-1];

    // External ROM: one-cycle read latency, noise on the data bus otherwise.
    always @(posedge clk)
        rom_bus.rom_data <= rom_bus.rom_en ? rom_mem[rom_bus.rom_addr] : 4'($urandom);

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    int m_busy, m_paused, m_bank, m_last, m_mode, m_pos;
    int f1_v, f1_a, f2_v, f2_a;
    int e_en, e_addr, e_leds, e_busy, e_done;

    int seen[$];
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Position counts steps through one period; ping-pong folds it back onto the bank.
    function automatic int pos_to_idx();
        if (m_mode == 2 && m_pos > m_last) return 2 * m_last - m_pos;
        return m_pos;
    endfunction

    task automatic model_step();
        int nf;
        nf = 0;
        if (rst) begin
            m_busy = 0; m_paused = 0; m_bank = 0; m_last = 0; m_mode = 0; m_pos = 0;
            f1_v = 0; f2_v = 0; f1_a = 0; f2_a = 0;
            e_en = 0; e_addr = 0; e_leds = 0; e_busy = 0; e_done = 0;
            return;
        end
        if (f2_v != 0) e_leds = rom_mem[f2_a];
        f2_v = f1_v; f2_a = f1_a;
        e_done = 0;
        if (stop) begin
            m_busy = 0; m_paused = 0;
        end else if (start) begin
            m_busy = 1; m_paused = 0; m_pos = 0;
            m_bank = bank; m_last = last; m_mode = mode;
            nf = 1;
        end else if (m_busy != 0 && pause) begin
            m_paused = (m_paused == 0);
        end else if (m_busy != 0 && m_paused == 0 && tick) begin
            if (m_mode == 1) begin
                m_pos = (m_pos + 1) % (m_last + 1); nf = 1;
            end else if (m_mode == 2) begin
                m_pos = (m_last == 0) ? 0 : (m_pos + 1) % (2 * m_last); nf = 1;
            end else if (m_pos == m_last) begin
                m_busy = 0; e_done = 1;
            end else begin
                m_pos++; nf = 1;
            end
        end
        if (nf != 0) e_addr = m_bank * BD + pos_to_idx();
        f1_v = nf; f1_a = e_addr;
        e_en = nf;
        e_busy = m_busy;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("rom_en",   32'(rom_bus.rom_en),   32'(e_en));
            chk("rom_addr", 32'(rom_bus.rom_addr), 32'(e_addr));
            chk("leds",     32'(leds),             32'(e_leds));
            chk("busy",     32'(busy),             32'(e_busy));
            chk("done",     32'(done),             32'(e_done));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rom_bus.rom_en === 1'b1) seen.push_back(int'(rom_bus.rom_addr));
        if (done === 1'b1) done_cnt++;
    end

    task automatic step(input logic r, input logic s, input logic st, input logic p, input logic t);
        rst = r; stop = s; start = st; pause = p; tick = t;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_seen(input string name, input int n, input int exp [8]);
        chk({name, "_count"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++)
            chk({name, "_addr"}, 32'(seen[i]), 32'(exp[i]));
        seen.delete();
    endtask

    initial begin
        int e[8];
        for (int i = 0; i < NB * BD; i++) rom_mem[i] = 4'($urandom_range(1, 15));
        bank = 0; last = 0; mode = 0;
        chk_on = 1'b1;

        step(1, 0, 0, 0, 0);
        chk("reset_leds", 32'(leds), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        step(0, 0, 0, 0, 0);
        seen.delete(); done_cnt = 0;

        bank = 1; last = 3; mode = 0;
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        e = '{16, 17, 18, 19, 0, 0, 0, 0};
        chk_seen("once_seq", 4, e);
        chk("once_done_cnt", 32'(done_cnt), 32'd1);
        chk("once_leds", 32'(leds), 32'(rom_mem[19]));
        chk("once_busy", 32'(busy), 32'd0);

        bank = 0; last = 2; mode = 1;
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        e = '{0, 1, 2, 0, 1, 2, 0, 0};
        chk_seen("loop_seq", 7, e);
        chk("loop_busy", 32'(busy), 32'd1);

        bank = 2; last = 2; mode = 2;
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        e = '{32, 33, 34, 33, 32, 33, 34, 0};
        chk_seen("pp_seq", 7, e);

        bank = 3; last = 7; mode = 1;
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        e = '{48, 49, 50, 51, 0, 0, 0, 0};
        chk_seen("pause_seq", 4, e);

        done_cnt = 0;
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk_seen("stop_seq", 0, e);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done_cnt", 32'(done_cnt), 32'd0);
        chk("stop_leds", 32'(leds), 32'(rom_mem[51]));

        bank = 1; last = 3; mode = 1;
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_mid_leds", 32'(leds), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        step(0, 0, 0, 0, 0);
        chk("rst_mid_leds_hold", 32'(leds), 32'd0);
        chk("rst_mid_done_cnt", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            bank = 2'($urandom);
            last = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            mode = 2'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
